// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Shares one FIR delay filter between NUM_CH ADC sample streams. Each channel's
// latest sample is held in a capture register with a pending flag; the filter is
// granted round-robin, fed through FIR_START/FIR_DIN, and its result is returned
// on DOUT tagged with the channel index on DOUT_CH.
// Optional build macro: FIR_SCHED_STATS_EN adds saturating SAMPLE_CNT/DROP_CNT outputs.
module fir_channel_scheduler #(
    parameter int BITSIZE = 12,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [NUM_CH-1:0]         CH_VALID,
    input  logic [NUM_CH*BITSIZE-1:0] CH_DATA,
    output logic                      FIR_START,
    output logic [BITSIZE-1:0]        FIR_DIN,
    input  logic [BITSIZE-1:0]        FIR_DOUT,
    input  logic                      FIR_VALID,
    output logic [BITSIZE-1:0]        DOUT,
    output logic [CH_W-1:0]           DOUT_CH,
    output logic                      DOUT_VALID,
    output logic [NUM_CH-1:0]         OVERRUN,
    output logic                      TIMEOUT_ERR,
    output logic                      BUSY
`ifdef FIR_SCHED_STATS_EN
    ,
    output logic [15:0]               SAMPLE_CNT,
    output logic [15:0]               DROP_CNT
`endif
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state;
    logic [NUM_CH-1:0]  pending;
    logic [BITSIZE-1:0] cap [NUM_CH];
    logic [CH_W-1:0]    grant;
    logic [CH_W-1:0]    last_grant;
    logic [CH_W-1:0]    sel_ch;
    logic [CH_W:0]      sel_idx;
    logic               sel_found;
    logic               grant_now;
    logic [NUM_CH-1:0]  issue_mask;
    logic [NUM_CH-1:0]  ovr_evt;
    logic               fir_valid_p0;
    logic               fir_rise;
    logic [CNT_W-1:0]   wait_cnt;

    // Round-robin search: first pending channel strictly after last_grant, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sel_idx = {1'b0, last_grant} + (CH_W+1)'(k);
            if (sel_idx >= (CH_W+1)'(NUM_CH)) begin
                sel_idx = sel_idx - (CH_W+1)'(NUM_CH);
            end
            if (!sel_found && pending[sel_idx[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = sel_idx[CH_W-1:0];
            end
        end
    end

    assign grant_now = (state == S_IDLE) && EN && sel_found;

    // One-hot of the channel being handed to the filter this cycle (empty otherwise).
    always_comb begin
        issue_mask = '0;
        if (grant_now) begin
            issue_mask[sel_ch] = 1'b1;
        end
    end

    // A strobe on a still-pending channel loses the older sample, unless that
    // older sample is leaving for the filter in this very cycle.
    assign ovr_evt  = CH_VALID & pending & ~issue_mask;
    assign fir_rise = FIR_VALID & ~fir_valid_p0;

    // Previous FIR_VALID level, used to detect the filter's rising edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fir_valid_p0 <= 1'b0;
        end else begin
            fir_valid_p0 <= FIR_VALID;
        end
    end

    // Per-channel capture registers, pending flags and sticky overrun flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= '0;
            OVERRUN <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cap[i] <= '0;
            end
        end else begin
            pending <= CH_VALID | (pending & ~issue_mask);
            OVERRUN <= OVERRUN | ovr_evt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_VALID[i]) begin
                    cap[i] <= CH_DATA[i*BITSIZE +: BITSIZE];
                end
            end
        end
    end

    // Scheduler FSM: grant, start pulse, wait for filter result or timeout, deliver.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            grant       <= '0;
            last_grant  <= CH_W'(NUM_CH - 1);
            wait_cnt    <= '0;
            FIR_START   <= 1'b0;
            FIR_DIN     <= '0;
            DOUT        <= '0;
            DOUT_CH     <= '0;
            DOUT_VALID  <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            FIR_START  <= 1'b0;
            DOUT_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        grant     <= sel_ch;
                        FIR_DIN   <= cap[sel_ch];
                        FIR_START <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    BUSY     <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (fir_rise) begin
                        DOUT    <= FIR_DOUT;
                        DOUT_CH <= grant;
                        state   <= S_OUT;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        // Abandon the sample but still move the round-robin pointer on.
                        TIMEOUT_ERR <= 1'b1;
                        last_grant  <= grant;
                        BUSY        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    DOUT_VALID <= 1'b1;
                    last_grant <= grant;
                    BUSY       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Delivered-sample and overrun-event counters, saturating at full scale.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SAMPLE_CNT <= '0;
            DROP_CNT   <= '0;
        end else begin
            if (state == S_OUT) begin
                SAMPLE_CNT <= sat_inc16(SAMPLE_CNT);
            end
            if (|ovr_evt) begin
                DROP_CNT <= sat_inc16(DROP_CNT);
            end
        end
    end
`endif

endmodule
